// File: rtl/decode_pkg.sv
// Opcode map, ALU command encodings and the opcode decode table for the ID stage.
package decode_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned EXE_W   = 4;

    localparam logic [OP_W-1:0] OP_NOP  = 6'd0;
    localparam logic [OP_W-1:0] OP_ADD  = 6'd1;
    localparam logic [OP_W-1:0] OP_SUB  = 6'd3;
    localparam logic [OP_W-1:0] OP_AND  = 6'd5;
    localparam logic [OP_W-1:0] OP_OR   = 6'd6;
    localparam logic [OP_W-1:0] OP_NOR  = 6'd7;
    localparam logic [OP_W-1:0] OP_XOR  = 6'd8;
    localparam logic [OP_W-1:0] OP_SLA  = 6'd9;
    localparam logic [OP_W-1:0] OP_SLL  = 6'd10;
    localparam logic [OP_W-1:0] OP_SRA  = 6'd11;
    localparam logic [OP_W-1:0] OP_SRL  = 6'd12;
    localparam logic [OP_W-1:0] OP_ADDI = 6'd32;
    localparam logic [OP_W-1:0] OP_SUBI = 6'd33;
    localparam logic [OP_W-1:0] OP_LD   = 6'd36;
    localparam logic [OP_W-1:0] OP_ST   = 6'd37;
    localparam logic [OP_W-1:0] OP_BEZ  = 6'd40;
    localparam logic [OP_W-1:0] OP_BNE  = 6'd41;
    localparam logic [OP_W-1:0] OP_JMP  = 6'd42;

    localparam logic [EXE_W-1:0] EXE_NOP = 4'd0;
    localparam logic [EXE_W-1:0] EXE_ADD = 4'd1;
    localparam logic [EXE_W-1:0] EXE_SUB = 4'd2;
    localparam logic [EXE_W-1:0] EXE_AND = 4'd3;
    localparam logic [EXE_W-1:0] EXE_OR  = 4'd4;
    localparam logic [EXE_W-1:0] EXE_NOR = 4'd5;
    localparam logic [EXE_W-1:0] EXE_XOR = 4'd6;
    localparam logic [EXE_W-1:0] EXE_SLA = 4'd7;
    localparam logic [EXE_W-1:0] EXE_SLL = 4'd8;
    localparam logic [EXE_W-1:0] EXE_SRA = 4'd9;
    localparam logic [EXE_W-1:0] EXE_SRL = 4'd10;

    typedef enum logic [1:0] {BR_NONE, BR_BEZ, BR_BNE, BR_JMP} br_type_e;

    typedef struct packed {
        logic [EXE_W-1:0] exe_cmd;
        logic             wb_en;
        logic             mem_r_en;
        logic             mem_w_en;
        logic             is_imm;
        logic             uses_src2;
        br_type_e         br_type;
    } ctrl_t;

    function automatic ctrl_t alu_rr(input logic [EXE_W-1:0] cmd);
        ctrl_t c;
        c           = '0;
        c.exe_cmd   = cmd;
        c.wb_en     = 1'b1;
        c.uses_src2 = 1'b1;
        return c;
    endfunction

    // Unknown opcodes fall through to an all-zero NOP.
    function automatic ctrl_t decode(input logic [OP_W-1:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_ADD:  c = alu_rr(EXE_ADD);
            OP_SUB:  c = alu_rr(EXE_SUB);
            OP_AND:  c = alu_rr(EXE_AND);
            OP_OR:   c = alu_rr(EXE_OR);
            OP_NOR:  c = alu_rr(EXE_NOR);
            OP_XOR:  c = alu_rr(EXE_XOR);
            OP_SLA:  c = alu_rr(EXE_SLA);
            OP_SLL:  c = alu_rr(EXE_SLL);
            OP_SRA:  c = alu_rr(EXE_SRA);
            OP_SRL:  c = alu_rr(EXE_SRL);
            OP_ADDI: begin c.exe_cmd = EXE_ADD; c.wb_en = 1'b1; c.is_imm = 1'b1; end
            OP_SUBI: begin c.exe_cmd = EXE_SUB; c.wb_en = 1'b1; c.is_imm = 1'b1; end
            OP_LD: begin
                c.exe_cmd  = EXE_ADD;
                c.wb_en    = 1'b1;
                c.mem_r_en = 1'b1;
                c.is_imm   = 1'b1;
            end
            OP_ST: begin
                c.exe_cmd   = EXE_ADD;
                c.mem_w_en  = 1'b1;
                c.is_imm    = 1'b1;
                c.uses_src2 = 1'b1;
            end
            OP_BEZ:  c.br_type = BR_BEZ;
            OP_BNE:  begin c.br_type = BR_BNE; c.uses_src2 = 1'b1; end
            OP_JMP:  c.br_type = BR_JMP;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// ID/EX pipeline register bundle: the decode stage drives it, EXE consumes it.
interface decode_stage_pipe_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
);
    import decode_pkg::*;

    logic              ex_valid;
    logic              ex_wb_en;
    logic              ex_mem_r_en;
    logic              ex_mem_w_en;
    logic [EXE_W-1:0]  ex_exe_cmd;
    logic [DATA_W-1:0] ex_val1;
    logic [DATA_W-1:0] ex_val2;
    logic [DATA_W-1:0] ex_st_val;
    logic [REG_AW-1:0] ex_dest;
    logic [REG_AW-1:0] ex_src1;
    logic [REG_AW-1:0] ex_src2;

    modport master (
        output ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_exe_cmd,
               ex_val1, ex_val2, ex_st_val, ex_dest, ex_src1, ex_src2
    );

    modport slave (
        input ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_exe_cmd,
              ex_val1, ex_val2, ex_st_val, ex_dest, ex_src1, ex_src2
    );

endinterface

// File: rtl/decode_stage_pipe_hazard_detect.sv
// Combinational RAW / load-use hazard check of the ID instruction against EXE and MEM.
module hazard_detect #(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned FORWARD_EN = 1
) (
    input  logic              if_valid,
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic              uses_src2,
    input  logic              is_branch,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              exe_wb_en,
    input  logic              exe_mem_r_en,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_wb_en,
    output logic              stall
);

    logic exe_hit;
    logic mem_hit;
    logic no_fwd;

    always_comb begin
        no_fwd  = (FORWARD_EN == 0);
        exe_hit = exe_wb_en && (exe_dest != '0) &&
                  ((exe_dest == src1) || (uses_src2 && (exe_dest == src2)));
        mem_hit = mem_wb_en && (mem_dest != '0) &&
                  ((mem_dest == src1) || (uses_src2 && (mem_dest == src2)));
        // Branches resolve in ID from raw register-file data, so they can never forward.
        stall   = if_valid && ((exe_hit && exe_mem_r_en) ||
                               (no_fwd && (exe_hit || mem_hit)) ||
                               (is_branch && (exe_hit || mem_hit)));
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage: opcode decode, hazard stall, in-ID branch resolution, ID/EX register
// and saturating stall/branch counters.
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned FORWARD_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_valid,
    input  logic [31:0]          instruction,
    input  logic [DATA_W-1:0]    pc,
    input  logic [DATA_W-1:0]    reg1,
    input  logic [DATA_W-1:0]    reg2,
    input  logic [REG_AW-1:0]    exe_dest,
    input  logic                 exe_wb_en,
    input  logic                 exe_mem_r_en,
    input  logic [REG_AW-1:0]    mem_dest,
    input  logic                 mem_wb_en,
    output logic [REG_AW-1:0]    src1,
    output logic [REG_AW-1:0]    src2,
    output logic                 stall,
    output logic                 br_taken,
    output logic [DATA_W-1:0]    br_addr,
    decode_stage_pipe_if.master  idex,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     br_cnt
);

    logic [OP_W-1:0]   opcode;
    ctrl_t             ctrl;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] val2;
    logic [REG_AW-1:0] dest;
    logic              is_branch;
    logic              cond;
    logic              issue;

    always_comb begin
        opcode    = instruction[31:26];
        ctrl      = decode(opcode);
        src1      = REG_AW'(instruction[25:21]);
        src2      = ((opcode == OP_ST) || (opcode == OP_BNE)) ? REG_AW'(instruction[20:16])
                                                              : REG_AW'(instruction[15:11]);
        dest      = REG_AW'(instruction[20:16]);
        imm       = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};
        val2      = ctrl.is_imm ? imm : reg2;
        is_branch = (ctrl.br_type != BR_NONE);
        br_addr   = pc + imm;
    end

    always_comb begin
        cond = 1'b0;
        case (ctrl.br_type)
            BR_BEZ:  cond = (reg1 == '0);
            BR_BNE:  cond = (reg1 != reg2);
            BR_JMP:  cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    hazard_detect #(
        .REG_AW     (REG_AW),
        .FORWARD_EN (FORWARD_EN)
    ) u_hazard (
        .if_valid     (if_valid),
        .src1         (src1),
        .src2         (src2),
        .uses_src2    (ctrl.uses_src2),
        .is_branch    (is_branch),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .stall        (stall)
    );

    assign issue    = if_valid && !stall;
    assign br_taken = issue && cond;

    // A stalled or empty slot loads an all-zero bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || !issue) begin
            idex.ex_valid    <= 1'b0;
            idex.ex_wb_en    <= 1'b0;
            idex.ex_mem_r_en <= 1'b0;
            idex.ex_mem_w_en <= 1'b0;
            idex.ex_exe_cmd  <= '0;
            idex.ex_val1     <= '0;
            idex.ex_val2     <= '0;
            idex.ex_st_val   <= '0;
            idex.ex_dest     <= '0;
            idex.ex_src1     <= '0;
            idex.ex_src2     <= '0;
        end else begin
            idex.ex_valid    <= 1'b1;
            idex.ex_wb_en    <= ctrl.wb_en;
            idex.ex_mem_r_en <= ctrl.mem_r_en;
            idex.ex_mem_w_en <= ctrl.mem_w_en;
            idex.ex_exe_cmd  <= ctrl.exe_cmd;
            idex.ex_val1     <= reg1;
            idex.ex_val2     <= val2;
            idex.ex_st_val   <= reg2;
            idex.ex_dest     <= dest;
            idex.ex_src1     <= src1;
            idex.ex_src2     <= src2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            br_cnt    <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (br_taken && (br_cnt != '1)) begin
                br_cnt <= br_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Scoreboard bench: two decode stages (forwarding/16-bit counters and no-forwarding/2-bit
// counters) share one directed stimulus stream; a monitor checks ID/EX against queued values.
module tb_decode_stage_pipe;
    import decode_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_valid;
    logic [31:0]   instruction;
    logic [DW-1:0] pc, reg1, reg2;
    logic [AW-1:0] exe_dest, mem_dest;
    logic          exe_wb_en, exe_mem_r_en, mem_wb_en;

    logic [AW-1:0] src1_a, src2_a, src1_b, src2_b;
    logic          stall_a, stall_b, br_a, br_b;
    logic [DW-1:0] baddr_a, baddr_b;
    logic [15:0]   scnt_a, bcnt_a;
    logic [1:0]    scnt_b, bcnt_b;

    decode_stage_pipe_if #(.DATA_W(DW), .REG_AW(AW)) ia ();
    decode_stage_pipe_if #(.DATA_W(DW), .REG_AW(AW)) ib ();

    always #5 clk = ~clk;

    decode_stage_pipe #(.DATA_W(DW), .REG_AW(AW), .CNT_W(16), .FORWARD_EN(1)) dut_a (
        .clk (clk), .rst (rst), .if_valid (if_valid), .instruction (instruction), .pc (pc),
        .reg1 (reg1), .reg2 (reg2), .exe_dest (exe_dest), .exe_wb_en (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en), .mem_dest (mem_dest), .mem_wb_en (mem_wb_en),
        .src1 (src1_a), .src2 (src2_a), .stall (stall_a), .br_taken (br_a),
        .br_addr (baddr_a), .idex (ia), .stall_cnt (scnt_a), .br_cnt (bcnt_a)
    );

    decode_stage_pipe #(.DATA_W(DW), .REG_AW(AW), .CNT_W(2), .FORWARD_EN(0)) dut_b (
        .clk (clk), .rst (rst), .if_valid (if_valid), .instruction (instruction), .pc (pc),
        .reg1 (reg1), .reg2 (reg2), .exe_dest (exe_dest), .exe_wb_en (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en), .mem_dest (mem_dest), .mem_wb_en (mem_wb_en),
        .src1 (src1_b), .src2 (src2_b), .stall (stall_b), .br_taken (br_b),
        .br_addr (baddr_b), .idex (ib), .stall_cnt (scnt_b), .br_cnt (bcnt_b)
    );

    typedef struct packed {
        logic        valid, wb, mr, mw;
        logic [3:0]  cmd;
        logic [31:0] val1, val2, st;
        logic [4:0]  dest, s1, s2;
        logic [15:0] scnt, bcnt;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   total = 0;
    int   bad   = 0;
    int   sa_cnt = 0, ba_cnt = 0, sb_cnt = 0, bb_cnt = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int c, input logic inc, input int max);
        return (inc && c < max) ? c + 1 : c;
    endfunction

    function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] s1, d, s2);
        return {op, s1, d, s2, 11'b0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] s1, d,
                                       input logic [15:0] imm);
        return {op, s1, d, imm};
    endfunction

    // Drive one ID-stage cycle, check same-cycle outputs, queue the ID/EX expectation.
    task automatic apply(input string name, input logic v, input logic [31:0] ins,
                         input logic [31:0] p, r1, r2, input logic [4:0] ed,
                         input logic ewb, emr, input logic [4:0] md, input logic mwb,
                         input logic sa, sb, cond, input logic [31:0] baddr,
                         input logic [4:0] s1, s2, input logic wb, mr, mw,
                         input logic [3:0] cmd, input logic [31:0] v1, v2, stv,
                         input logic [4:0] dest);
        exp_t ei, ea, eb;
        @(negedge clk);
        if_valid = v; instruction = ins; pc = p; reg1 = r1; reg2 = r2;
        exe_dest = ed; exe_wb_en = ewb; exe_mem_r_en = emr; mem_dest = md; mem_wb_en = mwb;
        #1;
        chk({name, ".src1"}, 256'(src1_a), 256'(s1));
        chk({name, ".src2"}, 256'(src2_b), 256'(s2));
        chk({name, ".stall_a"}, 256'(stall_a), 256'(sa));
        chk({name, ".stall_b"}, 256'(stall_b), 256'(sb));
        chk({name, ".br_a"}, 256'(br_a), 256'(v & ~sa & cond));
        chk({name, ".br_b"}, 256'(br_b), 256'(v & ~sb & cond));
        if (cond) chk({name, ".br_addr"}, 256'(baddr_a), 256'(baddr));
        ei = '{valid: 1'b1, wb: wb, mr: mr, mw: mw, cmd: cmd, val1: v1, val2: v2, st: stv,
               dest: dest, s1: s1, s2: s2, scnt: 16'd0, bcnt: 16'd0};
        sa_cnt = sat(sa_cnt, v & sa, 65535);
        ba_cnt = sat(ba_cnt, v & ~sa & cond, 65535);
        sb_cnt = sat(sb_cnt, v & sb, 3);
        bb_cnt = sat(bb_cnt, v & ~sb & cond, 3);
        ea = (v && !sa) ? ei : '0;
        eb = (v && !sb) ? ei : '0;
        ea.scnt = 16'(sa_cnt); ea.bcnt = 16'(ba_cnt);
        eb.scnt = 16'(sb_cnt); eb.bcnt = 16'(bb_cnt);
        qa.push_back(ea);
        qb.push_back(eb);
    endtask

    function automatic exp_t snap_a();
        return '{valid: ia.ex_valid, wb: ia.ex_wb_en, mr: ia.ex_mem_r_en, mw: ia.ex_mem_w_en,
                 cmd: ia.ex_exe_cmd, val1: ia.ex_val1, val2: ia.ex_val2, st: ia.ex_st_val,
                 dest: ia.ex_dest, s1: ia.ex_src1, s2: ia.ex_src2, scnt: scnt_a,
                 bcnt: bcnt_a};
    endfunction

    function automatic exp_t snap_b();
        return '{valid: ib.ex_valid, wb: ib.ex_wb_en, mr: ib.ex_mem_r_en, mw: ib.ex_mem_w_en,
                 cmd: ib.ex_exe_cmd, val1: ib.ex_val1, val2: ib.ex_val2, st: ib.ex_st_val,
                 dest: ib.ex_dest, s1: ib.ex_src1, s2: ib.ex_src2, scnt: {14'd0, scnt_b},
                 bcnt: {14'd0, bcnt_b}};
    endfunction

    // Monitor: every clock edge produces an ID/EX load (instruction or bubble).
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("idex_a", 256'(snap_a()), 256'(e));
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("idex_b", 256'(snap_b()), 256'(e));
            end
        end
    end

    initial begin
        logic [31:0] unk;
        unk = {6'd63, 26'd0};
        rst = 1'b1; if_valid = 1'b0; instruction = '0; pc = '0; reg1 = '0; reg2 = '0;
        exe_dest = '0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_dest = '0; mem_wb_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_a", 256'(snap_a()), 256'(0));
        chk("reset_b", 256'(snap_b()), 256'(0));
        rst = 1'b0;

        //    name      v  instr                         pc   r1   r2   ed ewb emr md mwb sa sb cnd baddr  s1 s2 wb mr mw cmd      val1 val2 st dest
        apply("add",    1, rr(OP_ADD, 1, 3, 2),          4,   5,   7,   0, 0, 0, 0, 0,   0, 0, 0, 0,     1, 2, 1, 0, 0, EXE_ADD, 5,  7,  7,  3);
        apply("ld_use", 1, rr(OP_ADD, 4, 5, 1),          8,   10,  3,   4, 1, 1, 0, 0,   1, 1, 0, 0,     4, 1, 1, 0, 0, EXE_ADD, 10, 3,  3,  5);
        apply("mem_raw",1, rr(OP_ADD, 4, 5, 1),          8,   10,  3,   0, 0, 0, 4, 1,   0, 1, 0, 0,     4, 1, 1, 0, 0, EXE_ADD, 10, 3,  3,  5);
        apply("mem_r0", 1, rr(OP_ADD, 4, 5, 1),          8,   10,  3,   0, 0, 0, 0, 1,   0, 0, 0, 0,     4, 1, 1, 0, 0, EXE_ADD, 10, 3,  3,  5);
        apply("exe_raw",1, rr(OP_SUB, 5, 6, 2),          12,  20,  8,   5, 1, 0, 0, 0,   0, 1, 0, 0,     5, 2, 1, 0, 0, EXE_SUB, 20, 8,  8,  6);
        apply("addi",   1, ri(OP_ADDI, 1, 7, 16'hFFFD),  16,  9,   55,  0, 0, 0, 31, 1,  0, 0, 0, 0,     1, 31, 1, 0, 0, EXE_ADD, 9, 32'hFFFF_FFFD, 55, 7);
        apply("ld",     1, ri(OP_LD, 2, 8, 16'd16),      20,  100, 0,   0, 0, 0, 0, 0,   0, 0, 0, 0,     2, 0, 1, 1, 0, EXE_ADD, 100, 16, 0, 8);
        apply("st_use", 1, ri(OP_ST, 3, 9, 16'hFFF8),    24,  200, 'hAB, 9, 1, 1, 0, 0,  1, 1, 0, 0,     3, 9, 0, 0, 1, EXE_ADD, 200, 32'hFFFF_FFF8, 'hAB, 9);
        apply("st",     1, ri(OP_ST, 3, 9, 16'hFFF8),    24,  200, 'hAB, 0, 0, 0, 0, 0,  0, 0, 0, 0,     3, 9, 0, 0, 1, EXE_ADD, 200, 32'hFFFF_FFF8, 'hAB, 9);
        apply("bne_t",  1, ri(OP_BNE, 1, 2, 16'hFFFC),   100, 1,   2,   0, 0, 0, 0, 0,   0, 0, 1, 96,    1, 2, 0, 0, 0, EXE_NOP, 1,  2,  2,  2);
        apply("bne_haz",1, ri(OP_BNE, 1, 2, 16'hFFFC),   100, 1,   2,   1, 1, 0, 0, 0,   1, 1, 1, 96,    1, 2, 0, 0, 0, EXE_NOP, 1,  2,  2,  2);
        apply("bne_nt", 1, ri(OP_BNE, 1, 2, 16'hFFFC),   100, 4,   4,   0, 0, 0, 0, 0,   0, 0, 0, 0,     1, 2, 0, 0, 0, EXE_NOP, 4,  4,  4,  2);
        apply("bez_t",  1, ri(OP_BEZ, 4, 0, 16'd8),      200, 0,   77,  0, 0, 0, 0, 0,   0, 0, 1, 208,   4, 0, 0, 0, 0, EXE_NOP, 0,  77, 77, 0);
        apply("jmp",    1, ri(OP_JMP, 0, 0, 16'h8000),   'h10, 3,  4,   0, 0, 0, 0, 1,   0, 0, 1, 32'hFFFF_8010, 0, 16, 0, 0, 0, EXE_NOP, 3, 4, 4, 0);
        apply("bez_wrap",1, ri(OP_BEZ, 0, 0, 16'h0020),  32'hFFFF_FFF0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h10, 0, 0, 0, 0, 0, EXE_NOP, 0, 0, 0, 0);
        apply("idle",   0, rr(OP_ADD, 4, 5, 1),          0,   1,   2,   4, 1, 1, 0, 0,   0, 0, 0, 0,     4, 1, 1, 0, 0, EXE_ADD, 1,  2,  2,  5);
        apply("unknown",1, unk,                          0,   11,  12,  0, 0, 0, 0, 0,   0, 0, 0, 0,     0, 0, 0, 0, 0, EXE_NOP, 11, 12, 12, 0);

        // Mid-stream reset: ID/EX still holds the last instruction and both counters are live.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_a", 256'(snap_a()), 256'(0));
        chk("midrst_b", 256'(snap_b()), 256'(0));
        sa_cnt = 0; ba_cnt = 0; sb_cnt = 0; bb_cnt = 0;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            apply("sat",  1, rr(OP_ADD, 4, 5, 1),        8,   10,  3,   4, 1, 1, 0, 0,   1, 1, 0, 0,     4, 1, 1, 0, 0, EXE_ADD, 10, 3,  3,  5);
        end
        apply("add2",   1, rr(OP_ADD, 4, 5, 1),          8,   10,  3,   0, 0, 0, 0, 0,   0, 0, 0, 0,     4, 1, 1, 0, 0, EXE_ADD, 10, 3,  3,  5);
        apply("bne_t2", 1, ri(OP_BNE, 1, 2, 16'hFFFC),   100, 1,   2,   0, 0, 0, 0, 0,   0, 0, 1, 96,    1, 2, 0, 0, 0, EXE_NOP, 1,  2,  2,  2);

        repeat (3) @(negedge clk);
        chk("drain", 256'(qa.size() + qb.size()), 256'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage_pipe.md
# decode_stage_pipe

Parametrised instruction-decode stage with an integrated ID/EX pipeline register, load-use and RAW hazard detection, in-stage branch resolution, and saturating stall/branch event counters. Sits between the IF/ID register and the EXE stage of the MIPS pipeline. Decodes the opcode, drives register-file read addresses, and resolves BEZ/BNE/JMP in ID. Registers a valid instruction or a bubble into ID/EX every cycle.

## Interface
Parameters:
- DATA_W, 32, datapath and PC width
- REG_AW, 5, register address width
- CNT_W, 16, event counter width
- FORWARD_EN, 1: 1 means EXE has forwarding, so only load-use hazards stall ALU ops; 0 means every RAW hazard stalls

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- if_valid  in  1  IF/ID holds a real instruction
- instruction  in  32  IF/ID instruction
- pc  in  DATA_W  incremented PC from IF/ID
- reg1, reg2  in  DATA_W  register-file read data for src1/src2
- exe_dest  in  REG_AW  destination register in EXE
- exe_wb_en, exe_mem_r_en  in  1  control bits of the instruction in EXE
- mem_dest  in  REG_AW  destination register in MEM
- mem_wb_en  in  1  control bit of the instruction in MEM
- src1, src2  out  REG_AW  register-file read addresses (combinational)
- stall  out  1  hold PC and IF/ID (combinational)
- br_taken  out  1  redirect PC and flush IF/ID (combinational)
- br_addr  out  DATA_W  branch target (combinational)
- ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en  out  1  ID/EX control bits
- ex_exe_cmd  out  4  ALU command
- ex_val1, ex_val2, ex_st_val  out  DATA_W  operand 1, operand 2 (register or immediate), store data
- ex_dest, ex_src1, ex_src2  out  REG_AW  destination and sources, for forwarding
- stall_cnt, br_cnt  out  CNT_W  event counters

## Operation
- **Source selection.** src1 = instr[25:21]. src2 = instr[20:16] for ST/BNE, else instr[15:11]. dest = instr[20:16].
- **Immediate.** imm = sign-extend(instr[15:0]) to DATA_W. val2 = imm if the opcode is immediate-type (ADDI, SUBI, LD, ST), else reg2. st_val = reg2.
- **Decode.** Opcode to {exe_cmd, wb_en, mem_r_en, mem_w_en, is_imm, uses_src2, br_type} comes from the package table. Unknown opcodes decode as NOP: all enables 0, exe_cmd 0.
- **Hazard match.** A match against a stage requires all of: that stage's wb_en = 1, its dest ≠ 0, and dest == src1, or dest == src2 with uses_src2 = 1.
- **Stall.** stall = if_valid & (A | B | C):
  - A: load-use match against EXE (exe_mem_r_en = 1).
  - B: FORWARD_EN = 0 and a match against EXE or MEM.
  - C: the instruction is a branch and matches EXE or MEM. Branch operands are never forwarded.
- **Branch.** br_taken = if_valid & ~stall & cond:
  - BEZ: cond = (reg1 == 0).
  - BNE: cond = (reg1 ≠ reg2).
  - JMP: cond = 1.
  - br_addr = pc + imm, modulo 2^DATA_W.
- **ID/EX load.** Every cycle, ID/EX loads either the decoded instruction or a bubble. A bubble sets all control bits and fields to 0. It is loaded when if_valid = 0 or stall = 1. Branches load with wb_en = mem_* = 0 and ex_valid = 1.
- **Counters.** stall_cnt increments on each cycle with stall = 1. br_cnt increments on each cycle with br_taken = 1. Both saturate at 2^CNT_W−1.
- **Reset.** Asynchronous; clears every ID/EX output and both counters to 0. Reset asserted mid-operation discards the in-flight instruction.

## Timing
- ID/EX outputs have 1-cycle latency: they are valid on the edge following decode.
- stall, br_taken, br_addr, src1, src2 are same-cycle combinational.
- A stall and a branch are never both reported in the same cycle; stall wins.
- While stall is high, IF/ID is held externally. This block re-evaluates the same instruction each cycle until stall drops, then issues it normally.
- Counter update occurs on the same edge as the ID/EX load.

## Structure
- Package decode_pkg holds:
  - opcode constants: NOP 0, ADD 1, SUB 3, AND 5, OR 6, NOR 7, XOR 8, SLA 9, SLL 10, SRA 11, SRL 12, ADDI 32, SUBI 33, LD 36, ST 37, BEZ 40, BNE 41, JMP 42
  - EXE_CMD constants
  - br_type enum {NONE, BEZ, BNE, JMP}
  - decode-table function
- One sub-module, hazard_detect: pure combinational, producing stall.
- ID/EX register and counters live in the top module.

## Test plan
- **Reset.** rst pulse mid-stream → all ex_* and both counters read 0 immediately.
- **ADD issue.** ADD r3,r1,r2 with reg1 = 5, reg2 = 7 → next cycle: ex_valid = 1, ex_exe_cmd = ADD, ex_val1 = 5, ex_val2 = 7, ex_dest = 3, ex_wb_en = 1.
- **Load-use.** LD r4 in EXE (exe_mem_r_en = 1, exe_dest = 4) while ADD r5,r4,r1 is in ID → stall = 1 for one cycle, bubble in ID/EX, stall_cnt = 1. Next cycle ADD issues.
- **BNE.** reg1 = 1, reg2 = 2, pc = 100, imm = −4 → br_taken = 1, br_addr = 96, br_cnt increments. The same instruction with exe_dest = src1 and exe_wb_en = 1 → stall = 1, br_taken = 0.
- **No-forward RAW.** FORWARD_EN = 0, MEM writes r2 while ADD reads r2 → stall = 1. The same case with mem_dest = 0 → no stall.
- **Saturation.** CNT_W = 2 with 5 consecutive stalls → stall_cnt holds at 3.
